// File: rtl/sinc_decim_pkg.sv
// sinc_decim_pkg: shared types and helpers for the sinc^N decimator.
// FSM state encoding, accumulator width rule and order limit.
package sinc_decim_pkg;

  localparam int ORDER_MAX = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t RUN    = 2'd2;

  function automatic int acc_width(int order, int max_sel);
    return order * (max_sel + 1) + 1;
  endfunction

endpackage

// File: rtl/sinc_chan.sv
// sinc_chan: one channel of synchroniser, integrators and combs.
// SINC_BIPOLAR_EN selects the signed +1/-1 input mapping.
module sinc_chan
  import sinc_decim_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int ACC_W = 25
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic             din,
  output logic [ACC_W-1:0] dout
);

  logic [1:0]       sync;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] int_q;
  logic [ACC_W-1:0] integ [ORDER];
  logic [ACC_W-1:0] dly   [ORDER];
  logic [ACC_W-1:0] c_in  [ORDER];
  logic [ACC_W-1:0] c_out [ORDER];

`ifdef SINC_BIPOLAR_EN
  assign x = sync[1] ? ACC_W'(1) : '1;
`else
  assign x = ACC_W'(sync[1]);
`endif

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    if (k == 0) begin : g_first
      assign c_in[k] = int_q;
    end else begin : g_next
      assign c_in[k] = c_out[k-1];
    end
    assign c_out[k] = c_in[k] - dly[k];
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      int_q <= '0;
      for (int k = 0; k < ORDER; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
    end else if (clear) begin
      sync  <= '0;
      int_q <= '0;
      for (int k = 0; k < ORDER; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
    end else begin
      sync     <= {sync[0], din};
      integ[0] <= integ[0] + x;
      for (int k = 1; k < ORDER; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
      // comb delays advance only at the decimated rate
      if (tick) begin
        int_q <= integ[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
          dly[k] <= c_in[k];
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (tick) begin
      dout <= c_out[ORDER-1];
    end
  end

endmodule

// File: rtl/sinc_decim_mc.sv
// sinc_decim_mc: multi-channel sinc^N decimator for 1-bit bitstreams.
// Define SINC_BIPOLAR_EN for signed +1/-1 input mapping.
module sinc_decim_mc
  import sinc_decim_pkg::*;
#(
  parameter int ORDER   = 3,
  parameter int NCH     = 4,
  parameter int MAX_SEL = 7
) (
  input  logic                                    mclk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic [3:0]                              dec_sel,
  input  logic [NCH-1:0]                          data_in,
  output logic [NCH*acc_width(ORDER,MAX_SEL)-1:0] data_out,
  output logic                                    out_valid,
  output logic                                    settled,
  output logic [3:0]                              sel_q
);

  localparam int ACC_W = acc_width(ORDER, MAX_SEL);

  state_t     state;
  logic [9:0] cnt;
  logic       bit_q;
  logic [2:0] scnt;
  logic       run;
  logic       tick;
  logic       clear;

  assign run     = (state != IDLE) && en;
  assign tick    = run && cnt[sel_q] && !bit_q;
  assign clear   = (state == IDLE);
  assign settled = (state == RUN);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      bit_q <= 1'b0;
    end else if (run) begin
      cnt   <= cnt + 10'd1;
      bit_q <= cnt[sel_q];
    end else begin
      cnt   <= '0;
      bit_q <= 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      scnt      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= tick && (state == RUN);
      case (state)
        IDLE: begin
          scnt <= '0;
          if (en) begin
            state <= SETTLE;
            sel_q <= (dec_sel > 4'(MAX_SEL)) ? 4'(MAX_SEL) : dec_sel;
          end
        end
        SETTLE: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick) begin
            // ORDER+1 ticks flush the comb delay line
            if (scnt == 3'(ORDER)) begin
              state <= RUN;
              scnt  <= '0;
            end else begin
              scnt <= scnt + 3'd1;
            end
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sinc_chan #(
      .ORDER (ORDER),
      .ACC_W (ACC_W)
    ) u_chan (
      .mclk  (mclk),
      .rst   (rst),
      .clear (clear),
      .tick  (tick),
      .din   (data_in[c]),
      .dout  (data_out[c*ACC_W +: ACC_W])
    );
  end

endmodule

// File: doc/sinc_decim_mc.md
Name: sinc_decim_mc

Overview:
- Parametrised multi-channel sinc^N (CIC) decimation filter for 1-bit sigma-delta modulator bitstreams. Data-preprocessing front end ahead of the CNN feature pipeline.
- Generalises the fixed sinc3 filter:
  - configurable order and channel count;
  - runtime decimation ratio latched safely at start;
  - enable control;
  - settling suppression;
  - explicit output-valid strobe.

Parameters:
- ORDER, 3: filter order N (integrator/comb stages), legal 1..5.
- NCH, 4: number of independent bitstream channels.
- MAX_SEL, 7: largest legal dec_sel; max ratio R = 2^(MAX_SEL+1).
- ACC_W, ORDER*(MAX_SEL+1)+1: accumulator/output width per channel (derived, not overridden).

Ports:
- mclk  in  1  modulator clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  filter run enable.
- dec_sel  in  4  ratio select; R = 2^(dec_sel+1).
- data_in  in  NCH  one bitstream bit per channel.
- data_out  out  NCH*ACC_W  channel c at bits [c*ACC_W +: ACC_W].
- out_valid  out  1  one-cycle strobe, data_out updated.
- settled  out  1  high while in RUN.
- sel_q  out  4  ratio select actually in use.

Behaviour:
- Reset (rst=1, asynchronous): everything cleared to 0, FSM=IDLE.
  - Cleared: data_out, out_valid, settled, sel_q, synchronisers, integrators, comb delay registers, decimation counter, settle counter.
- Input path: each data_in bit passes a 2-flop synchroniser before integrator 1.
  - Unsigned mapping: 1 -> +1, 0 -> 0, zero-extended to ACC_W.
- Integrators: ORDER cascaded registered accumulators at mclk rate, modulo 2^ACC_W (wrap intended, no saturation).
- Decimation:
  - 10-bit free-running counter cnt, counting only in SETTLE/RUN.
  - tick = rising edge of cnt[sel_q], detected via a registered copy; one tick per 2^(sel_q+1) cycles.
- Combs:
  - On tick, last integrator output is captured into int_q.
  - ORDER cascaded combs: y = x - x_delay, with x_delay loaded only on tick; modulo 2^ACC_W.
- Output: on tick, data_out <= last comb output; out_valid pulses in the same cycle as the data_out update, only in RUN.
- FSM:
  - IDLE: holds datapath cleared.
    - en=1 -> SETTLE.
    - sel_q <= min(dec_sel, MAX_SEL) on that transition.
  - SETTLE: counts ticks.
    - After ORDER+1 ticks -> RUN.
    - No out_valid in SETTLE.
    - data_out still updates but carries no meaning.
  - RUN: settled=1; every tick produces out_valid.
  - en=0 in SETTLE or RUN -> IDLE next cycle; datapath cleared, data_out holds last value, out_valid=0.
- dec_sel changes while not in IDLE are ignored until the next IDLE->SETTLE transition.
- Out-of-range dec_sel > MAX_SEL is clamped to MAX_SEL.
- Steady state (unsigned): a constant all-ones input gives R^ORDER; the full-scale value equals 2^(ACC_W-1) at R max.
- Simultaneous en falling with a tick: en wins; no out_valid.

Optional Feature:
- Macro SINC_BIPOLAR_EN.
  - Defined: input mapped 1 -> +1, 0 -> -1 (two's complement, sign-extended to ACC_W); data_out is signed.
  - Undefined: unsigned 0/+1 mapping as above.
- FSM and timing are identical either way.

Decomposition:
- Package sinc_decim_pkg:
  - FSM state typedef (IDLE, SETTLE, RUN);
  - acc_width(order, max_sel) function;
  - ORDER_MAX=5 constant.
- Sub-module sinc_chan: one channel's synchroniser, integrators and combs.
  - Inputs: tick and clear.
  - Instantiated NCH times via generate.
- The top level holds the counter, tick detection, FSM and sel_q.

Test Plan:
- ORDER=3, MAX_SEL=7, dec_sel=3 (R=16), all ones, en=1:
  - no out_valid for the first 4 ticks;
  - then out_valid every 16 cycles with data_out=4096, settled=1.
- dec_sel=7 (R=256), all ones -> data_out=16777216 (2^24), no overflow in 25 bits.
- Channel 0 all ones, channel 1 alternating 1010, channel 2 all zeros, channel 3 all ones, R=16 -> 4096 / 2048 / 0 / 4096 per channel.
- dec_sel changed 3->1 during RUN:
  - output stays at 4096 (sel_q=3);
  - then en low for 2 cycles and high again -> sel_q=1, settles, data_out=64 every 4 cycles.
- dec_sel=12 -> sel_q=7 (clamp); rst pulsed mid-RUN -> all outputs 0 and IDLE immediately, asynchronously.
- SINC_BIPOLAR_EN defined, all zeros, R=16 -> data_out=-4096 (0x1FFF000 in 25 bits); alternating -> 0.
